cell_scan_sequencer: RTL and testbench



---
 rtl/cell_scan_sequencer_if.sv | 31 +++
 rtl/cell_scan_sequencer.sv | 108 ++++++++++
 tb/tb_cell_scan_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_scan_sequencer_if.sv
// rtl/cell_scan_sequencer_if.sv - divider port and cell beat stream of the scan sequencer
interface cell_scan_sequencer_if #(
  parameter int N_WIDTH = 10,
  parameter int D_WIDTH = 8
);
  logic [N_WIDTH-1:0] div_num;
  logic [D_WIDTH-1:0] div_den;
  logic [N_WIDTH-1:0] div_quot;
  logic [D_WIDTH-1:0] div_rem;

  logic               out_valid;
  logic               out_ready;
  logic [N_WIDTH-1:0] out_index;
  logic [N_WIDTH-1:0] out_row;
  logic [D_WIDTH-1:0] out_col;
  logic               out_last;

  modport master (
    output div_num, div_den,
    input  div_quot, div_rem,
    output out_valid, out_index, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  div_num, div_den,
    output div_quot, div_rem,
    input  out_valid, out_index, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/cell_scan_sequencer.sv
// rtl/cell_scan_sequencer.sv - raster sweep of the Life grid, one cell beat per clock
module cell_scan_sequencer #(
  parameter int N_WIDTH = 10,
  parameter int D_WIDTH = 8,
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  cell_scan_sequencer_if.master bus
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam logic [N_WIDTH-1:0] LAST_IDX = N_WIDTH'(CELLS - 1);

  if (CELLS > (2 ** N_WIDTH)) begin : g_bad_cells
    $error("cell_scan_sequencer: GRID_W*GRID_H exceeds the index range");
  end
  if (GRID_W >= (2 ** D_WIDTH)) begin : g_bad_width
    $error("cell_scan_sequencer: GRID_W does not fit the divisor width");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t             state;
  logic [N_WIDTH-1:0] idx;
  logic               out_valid;
  logic [N_WIDTH-1:0] out_index;
  logic [N_WIDTH-1:0] out_row;
  logic [D_WIDTH-1:0] out_col;
  logic               out_last;

  // The external divider is combinational, so quotient/remainder of idx are
  // available in the same cycle and get captured alongside idx itself.
  assign bus.div_num   = idx;
  assign bus.div_den   = D_WIDTH'(GRID_W);
  assign bus.out_valid = out_valid;
  assign bus.out_index = out_index;
  assign bus.out_row   = out_row;
  assign bus.out_col   = out_col;
  assign bus.out_last  = out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        idx       <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              idx   <= '0;
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
          SCAN: begin
            if (!out_valid || bus.out_ready) begin
              out_index <= idx;
              out_row   <= bus.div_quot;
              out_col   <= bus.div_rem;
              out_valid <= 1'b1;
              out_last  <= (idx == LAST_IDX);
              if (idx == LAST_IDX) begin
                state <= DRAIN;
              end else begin
                idx <= idx + 1'b1;
              end
            end
            // Otherwise the beat is stalled (valid && !ready): hold everything.
          end
          DRAIN: begin
            if (out_valid && bus.out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cell_scan_sequencer.sv
// tb/tb_cell_scan_sequencer.sv - directed bench for cell_scan_sequencer
module tb_cell_scan_sequencer;
  localparam int N_WIDTH = 10;
  localparam int D_WIDTH = 8;
  localparam int CELLS   = 768;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;
  int   total = 0;
  int   bad   = 0;

  cell_scan_sequencer_if #(.N_WIDTH(N_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

  cell_scan_sequencer #(
    .N_WIDTH(N_WIDTH), .D_WIDTH(D_WIDTH), .GRID_W(32), .GRID_H(24)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // external combinational divider
  assign bus.div_quot = bus.div_num / {2'b00, bus.div_den};
  assign bus.div_rem  = D_WIDTH'(bus.div_num % {2'b00, bus.div_den});

  task automatic start_sweep();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.out_valid === 1'b1 && bus.out_index === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
    end
    start = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_last, done, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {bus.out_valid, bus.out_last, done, busy});
    end
    total++;
    if (bus.out_index !== 0 || bus.out_row !== 0 || bus.out_col !== 0) begin
      bad++; $display("FAIL reset_beat got idx=%0d row=%0d col=%0d want 0/0/0", bus.out_index, bus.out_row, bus.out_col);
    end
    total++;
    if (bus.div_num !== 0 || bus.div_den !== 32) begin
      bad++; $display("FAIL reset_div got num=%0d den=%0d want 0/32", bus.div_num, bus.div_den);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release_idle got busy=%b valid=%b want 0/0", busy, bus.out_valid);
    end
  endtask

  task automatic test_full_sweep();
    int nerr;
    nerr = 0;
    bus.out_ready = 1'b1;
    start_sweep();
    total++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL sweep_latency got busy=%b valid=%b want 1/0", busy, bus.out_valid);
    end
    for (int e = 0; e < CELLS; e++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_index !== e || bus.out_row !== e / 32 ||
          bus.out_col !== e % 32 || bus.out_last !== (e == CELLS - 1) || done !== 1'b0) begin
        nerr++;
        if (nerr < 4) $display("FAIL sweep_beat got idx=%0d row=%0d col=%0d last=%b want idx=%0d", bus.out_index, bus.out_row, bus.out_col, bus.out_last, e);
      end
      if (e == 31) begin
        total++;
        if (bus.out_row !== 0 || bus.out_col !== 31) begin
          bad++; $display("FAIL spot_31 got row=%0d col=%0d want 0/31", bus.out_row, bus.out_col);
        end
      end
      if (e == 32) begin
        total++;
        if (bus.out_row !== 1 || bus.out_col !== 0) begin
          bad++; $display("FAIL spot_32 got row=%0d col=%0d want 1/0", bus.out_row, bus.out_col);
        end
      end
      if (e == 767) begin
        total++;
        if (bus.out_row !== 23 || bus.out_col !== 31 || bus.out_last !== 1'b1) begin
          bad++; $display("FAIL spot_767 got row=%0d col=%0d last=%b want 23/31/1", bus.out_row, bus.out_col, bus.out_last);
        end
      end
    end
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL sweep_beats got %0d bad beats want 0", nerr);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL sweep_done got done=%b busy=%b valid=%b want 1/0/0", done, busy, bus.out_valid);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL done_restart got done=%b busy=%b want 0/1", done, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b1;
    start_sweep();
    run_to(40, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_reach got timeout want beat 40");
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 40 || bus.out_row !== 1 ||
          bus.out_col !== 8 || bus.out_last !== 1'b0 || bus.div_num !== 41) begin
        bad++; $display("FAIL bp_hold got idx=%0d row=%0d col=%0d num=%0d want 40/1/8/41", bus.out_index, bus.out_row, bus.out_col, bus.div_num);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 41 || bus.out_row !== 1 || bus.out_col !== 9) begin
      bad++; $display("FAIL bp_resume got idx=%0d row=%0d col=%0d want 41/1/9", bus.out_index, bus.out_row, bus.out_col);
    end
    @(negedge clk);
    total++;
    if (bus.out_index !== 42) begin
      bad++; $display("FAIL bp_next got idx=%0d want 42", bus.out_index);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    int dones;
    dones = 0;
    bus.out_ready = 1'b1;
    start_sweep();
    run_to(100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL abort_reach got timeout want beat 100");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0 || bus.div_num !== 0) begin
      bad++; $display("FAIL abort_state got valid=%b last=%b busy=%b num=%0d want 0/0/0/0", bus.out_valid, bus.out_last, busy, bus.div_num);
    end
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL abort_no_done got %0d done pulses want 0", dones);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_beats_start got busy=%b want 0", busy);
    end
    start_sweep();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 0 || bus.out_row !== 0 || bus.out_col !== 0) begin
      bad++; $display("FAIL abort_restart got valid=%b idx=%0d want 1/0", bus.out_valid, bus.out_index);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit ok;
    int nerr;
    nerr = 0;
    bus.out_ready = 1'b1;
    start_sweep();
    run_to(300, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL ign_reach got timeout want beat 300");
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 301; e < CELLS; e++) begin
      if (bus.out_valid !== 1'b1 || bus.out_index !== e) begin
        nerr++;
        if (nerr < 4) $display("FAIL ign_beat got idx=%0d want %0d", bus.out_index, e);
      end
      @(negedge clk);
    end
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL ign_beats got %0d bad beats want 0", nerr);
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL ign_done got done=%b want 1", done);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL ign_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_random_ready();
    int  expn;
    int  dones;
    int  nerr;
    bit  r;
    expn  = 0;
    dones = 0;
    nerr  = 0;
    bus.out_ready = 1'b0;
    start_sweep();
    for (int c = 0; c < 6000; c++) begin
      if (done === 1'b1) begin
        dones++;
        break;
      end
      if (bus.out_valid === 1'b1) begin
        if (bus.out_index !== expn || bus.out_row !== expn / 32 || bus.out_col !== expn % 32 ||
            bus.out_last !== (expn == CELLS - 1)) begin
          nerr++;
          if (nerr < 4) $display("FAIL rand_beat got idx=%0d last=%b want idx=%0d", bus.out_index, bus.out_last, expn);
        end
      end
      r = 1'($urandom_range(0, 1));
      bus.out_ready = r;
      if (bus.out_valid === 1'b1 && r) expn++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (expn != CELLS) begin
      bad++; $display("FAIL rand_count got %0d beats want %0d", expn, CELLS);
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL rand_done got %0d done pulses want 1", dones);
    end
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL rand_order got %0d bad beats want 0", nerr);
    end
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    int dones;
    dones = 0;
    bus.out_ready = 1'b1;
    start_sweep();
    run_to(767, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL drain_reach got timeout want beat 767");
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL drain_hold got valid=%b last=%b busy=%b want 1/1/1", bus.out_valid, bus.out_last, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_last, busy, done} !== 4'b0000 || bus.out_index !== 0 || bus.div_num !== 0) begin
      bad++; $display("FAIL drain_async_reset got flags=%b idx=%0d num=%0d want 0000/0/0", {bus.out_valid, bus.out_last, busy, done}, bus.out_index, bus.div_num);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL drain_no_done got dones=%0d busy=%b want 0/0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_random_ready();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
